run_sequencer: RTL and testbench

- Host-side run controller for the 9-bit-ISA processor core.
- Drives the core's start/init input and consumes its halt flag.
- Sequence: preload the data memory over a stream port, release the core, wait for halt (with timeout), then stream back a window of data memory for checking.
- Sits between the testbench/host and the processor core plus its data memory.

---
 rtl/run_sequencer.sv | 172 +++++++++++++++++
 tb/tb_run_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// -----------------------------------------------------------------------------
// run_sequencer
//
// Host-side run controller for the 9-bit-ISA processor core. A run is:
// preload data memory from a stream port, hold the core in init for a few
// cycles, release it, wait for halt (with a cycle-count timeout), then stream a
// window of data memory back out for checking.
//
// Ports
//   CLK, reset          clock (posedge), asynchronous active-high reset
//   go                  run request, only honoured in IDLE
//   dump_base/dump_len  readback window, latched when go is accepted
//   ld_valid/ld_ready   preload stream handshake; ld_addr/ld_data/ld_last beat
//   dut_start           core init/start (high = hold core in init)
//   dut_halt            core halt flag
//   host_sel            1 = this block owns the data memory port
//   mem_addr/mem_wr/    host-side data memory port; mem_rdata is combinational
//   mem_wdata/mem_rdata from mem_addr
//   rd_valid/rd_ready   readback stream handshake; rd_data/rd_last beat
//   busy                any state other than IDLE
//   done, timed_out     sticky run status, cleared when the next go is accepted
//   cycles              RUN-cycle count of the last run
// -----------------------------------------------------------------------------
module run_sequencer #(
    parameter int          AW           = 8,
    parameter int          DW           = 8,
    parameter int          START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          go,
    input  logic [AW-1:0] dump_base,
    input  logic [AW:0]   dump_len,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          dut_start,
    input  logic          dut_halt,
    output logic          host_sel,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          busy,
    output logic          done,
    output logic          timed_out,
    output logic [15:0]   cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP, S_DONE
    } state_t;

    localparam logic [AW:0] MAX_LEN   = {1'b1, {AW{1'b0}}};
    localparam logic [15:0] START_END = 16'(START_CYCLES - 1);

    state_t        state_q, state_d;
    logic          ld_ready_q, dut_start_q, host_sel_q, busy_q, rd_valid_q;
    logic          done_q, timed_out_q;
    logic [15:0]   cycles_q;
    logic [15:0]   start_cnt_q;
    logic [AW:0]   idx_q;
    logic [AW-1:0] base_q;
    logic [AW:0]   len_q;
    logic          last_beat;

    assign last_beat = (idx_q == len_q - 1'b1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (go) state_d = S_LOAD;
            S_LOAD:  if (ld_valid && ld_last) state_d = S_START;
            // Stale halt from the previous program is ignored until RUN.
            S_START: if (start_cnt_q == START_END) state_d = S_RUN;
            S_RUN: begin
                // Halt takes priority over a coincident timeout.
                if (dut_halt)
                    state_d = (len_q == '0) ? S_DONE : S_DUMP;
                else if (cycles_q == TIMEOUT)
                    state_d = S_DONE;
            end
            S_DUMP:  if (rd_ready && last_beat) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and status. The Moore outputs are registered from the
    // next state so they change cleanly on the clock edge without decode
    // glitches.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ld_ready_q  <= 1'b0;
            dut_start_q <= 1'b1;
            host_sel_q  <= 1'b1;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
            cycles_q    <= '0;
            start_cnt_q <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            ld_ready_q  <= (state_d == S_LOAD);
            dut_start_q <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_START);
            host_sel_q  <= (state_d != S_RUN);
            busy_q      <= (state_d != S_IDLE);
            rd_valid_q  <= (state_d == S_DUMP);
            unique case (state_q)
                S_IDLE: begin
                    if (go) begin
                        done_q      <= 1'b0;
                        timed_out_q <= 1'b0;
                        cycles_q    <= '0;
                        start_cnt_q <= '0;
                        idx_q       <= '0;
                    end
                end
                S_START: start_cnt_q <= start_cnt_q + 16'd1;
                S_RUN: begin
                    // The timeout cycle itself is not counted, so a timed-out
                    // run reports exactly TIMEOUT.
                    if (!dut_halt) begin
                        if (cycles_q == TIMEOUT)
                            timed_out_q <= 1'b1;
                        else if (cycles_q != 16'hFFFF)
                            cycles_q <= cycles_q + 16'd1;
                    end
                end
                S_DUMP:  if (rd_ready) idx_q <= idx_q + 1'b1;
                S_DONE:  done_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Readback window; only meaningful after go, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (state_q == S_IDLE && go) begin
            base_q <= dump_base;
            len_q  <= (dump_len > MAX_LEN) ? MAX_LEN : dump_len;
        end
    end

    assign ld_ready  = ld_ready_q;
    assign dut_start = dut_start_q;
    assign host_sel  = host_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timed_out = timed_out_q;
    assign cycles    = cycles_q;

    // Preload writes pass straight through; the dump address wraps mod 2^AW.
    assign mem_wr    = (state_q == S_LOAD) && ld_valid;
    assign mem_wdata = ld_data;
    assign mem_addr  = (state_q == S_LOAD) ? ld_addr : base_q + idx_q[AW-1:0];

    assign rd_valid  = rd_valid_q;
    assign rd_data   = mem_rdata;
    assign rd_last   = rd_valid_q && last_beat;

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

    logic        CLK = 1'b0;
    logic        reset, go, ld_valid, ld_last, dut_halt, rd_ready;
    logic [7:0]  dump_base, ld_addr, ld_data;
    logic [8:0]  dump_len;
    logic        ld_ready, dut_start, host_sel, mem_wr, rd_valid, rd_last;
    logic        busy, done, timed_out;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata, rd_data;
    logic [15:0] cycles;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_hs  = 0;

    // Expected preload writes {addr,data} and readback beats {last,addr,data}.
    logic [15:0] wq[$];
    logic [16:0] rq[$];

    // Data memory model: unwritten locations read as addr + 8'h30.
    logic [7:0] mem [256];
    bit         written [256];

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_wr && host_sel) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
    end

    assign mem_rdata = written[mem_addr] ? mem[mem_addr] : mem_addr + 8'h30;

    run_sequencer #(.AW(8), .DW(8), .START_CYCLES(2), .TIMEOUT(16'd20)) dut (
        .CLK(CLK), .reset(reset), .go(go), .dump_base(dump_base), .dump_len(dump_len),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_last(ld_last), .dut_start(dut_start), .dut_halt(dut_halt), .host_sel(host_sel),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .busy(busy), .done(done), .timed_out(timed_out), .cycles(cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle on the falling edge.
    initial begin
        logic       stall_prev;
        logic [7:0] prev_addr, prev_data;
        logic [15:0] ew;
        logic [16:0] er;
        stall_prev = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge CLK);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (mem_wr) begin
                    wr_cnt++;
                    if (wq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
                    else begin
                        ew = wq.pop_front();
                        chk("wr_beat", 32'({mem_addr, mem_wdata}), 32'(ew));
                    end
                end
                if (stall_prev) begin
                    chk("stall_valid", 32'(rd_valid), 32'd1);
                    chk("stall_addr", 32'(mem_addr), 32'(prev_addr));
                    chk("stall_data", 32'(rd_data), 32'(prev_data));
                end
                if (rd_valid && rd_ready) begin
                    rd_hs++;
                    if (rq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                    else begin
                        er = rq.pop_front();
                        chk("rd_beat", 32'({rd_last, mem_addr, rd_data}), 32'(er));
                    end
                end
                stall_prev = rd_valid && !rd_ready;
                prev_addr  = mem_addr;
                prev_data  = rd_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_run(input logic [7:0] base, input logic [8:0] len);
        dump_base = base;
        dump_len  = len;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    // One preload beat, preceded by an idle cycle so ld_valid toggles.
    task automatic load_beat(input logic [7:0] a, input logic [7:0] d, input logic l);
        int n = 0;
        ld_valid = 1'b0;
        tick();
        ld_addr  = a;
        ld_data  = d;
        ld_last  = l;
        ld_valid = 1'b1;
        wq.push_back({a, d});
        while (!ld_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("ld_ready_timeout", 32'd0, 32'd1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int hs_before;
        int n;
        reset = 1'b1; go = 1'b0; dump_base = '0; dump_len = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
        dut_halt = 1'b0; rd_ready = 1'b1;

        // Reset values
        #3;
        chk("rst_dut_start", 32'(dut_start), 32'd1);
        chk("rst_host_sel", 32'(host_sel), 32'd1);
        chk("rst_outs_low", 32'({ld_ready, mem_wr, rd_valid, rd_last, busy, done, timed_out}), 32'd0);
        chk("rst_cycles", 32'(cycles), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Tests 1-3: preload, stale halt ignored, 10-cycle run, stalled dump
        dut_halt = 1'b1;
        start_run(8'h40, 9'd4);
        chk("load_busy", 32'(busy), 32'd1);
        load_beat(8'h00, 8'hA5, 1'b0);
        load_beat(8'h01, 8'h5A, 1'b0);
        load_beat(8'h02, 8'hFF, 1'b1);
        chk("start_c1", 32'(dut_start), 32'd1);
        tick();
        chk("start_c2", 32'(dut_start), 32'd1);
        tick();
        chk("start_release", 32'(dut_start), 32'd0);
        chk("run_host_sel", 32'(host_sel), 32'd0);
        chk("wr_pulses", 32'(wr_cnt), 32'd3);
        chk("wr_queue_empty", 32'(wq.size()), 32'd0);
        dut_halt = 1'b0;
        for (int i = 0; i < 4; i++)
            rq.push_back({(i == 3), 8'h40 + 8'(i), 8'h70 + 8'(i)});
        repeat (10) tick();
        dut_halt = 1'b1;
        tick();
        dut_halt = 1'b0;
        chk("halt_cycles", 32'(cycles), 32'd10);
        chk("dump_host_sel", 32'(host_sel), 32'd1);
        chk("dump_dut_start", 32'(dut_start), 32'd0);
        tick();
        rd_ready = 1'b0;
        repeat (5) tick();
        rd_ready = 1'b1;
        wait_done("done_t2");
        chk("t2_rq_empty", 32'(rq.size()), 32'd0);
        chk("t2_timed_out", 32'(timed_out), 32'd0);
        chk("t2_cycles", 32'(cycles), 32'd10);
        chk("t2_idle_start", 32'({busy, dut_start}), 32'b01);

        // Test 4: timeout with no halt
        hs_before = rd_hs;
        start_run(8'h00, 9'd4);
        chk("go_clears_done", 32'(done), 32'd0);
        load_beat(8'h80, 8'h77, 1'b1);
        wait_done("done_t4");
        chk("t4_timed_out", 32'(timed_out), 32'd1);
        chk("t4_cycles", 32'(cycles), 32'd20);
        chk("t4_no_readback", 32'(rd_hs), 32'(hs_before));

        // Test 5: wrapping dump window, then zero-length dump
        dut_halt = 1'b1;
        rq.push_back({1'b0, 8'hFE, 8'h2E});
        rq.push_back({1'b0, 8'hFF, 8'h2F});
        rq.push_back({1'b0, 8'h00, 8'hA5});
        rq.push_back({1'b1, 8'h01, 8'h5A});
        start_run(8'hFE, 9'd4);
        chk("go_clears_timed_out", 32'(timed_out), 32'd0);
        load_beat(8'h80, 8'h77, 1'b1);
        wait_done("done_t5a");
        chk("t5a_rq_empty", 32'(rq.size()), 32'd0);
        chk("t5a_cycles", 32'(cycles), 32'd0);
        hs_before = rd_hs;
        start_run(8'h40, 9'd0);
        load_beat(8'h80, 8'h77, 1'b1);
        wait_done("done_t5b");
        chk("t5b_no_readback", 32'(rd_hs), 32'(hs_before));
        chk("t5b_timed_out", 32'(timed_out), 32'd0);

        // Test 6a: reset during RUN
        dut_halt = 1'b0;
        start_run(8'h40, 9'd4);
        load_beat(8'h80, 8'h77, 1'b1);
        repeat (5) tick();
        chk("t6a_in_run", 32'(host_sel), 32'd0);
        #3 reset = 1'b1;
        #1;
        chk("t6a_rst_start_sel", 32'({dut_start, host_sel}), 32'b11);
        chk("t6a_rst_low", 32'({busy, rd_valid, done, timed_out}), 32'd0);
        chk("t6a_rst_cycles", 32'(cycles), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Test 6b: reset during DUMP (stalled)
        dut_halt = 1'b1;
        rd_ready = 1'b0;
        start_run(8'h40, 9'd4);
        load_beat(8'h80, 8'h77, 1'b1);
        n = 0;
        while (!rd_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t6b_dump_entered", 32'(rd_valid), 32'd1);
        tick();
        #3 reset = 1'b1;
        #1;
        chk("t6b_rst_start_sel", 32'({dut_start, host_sel}), 32'b11);
        chk("t6b_rst_low", 32'({busy, rd_valid, rd_last, done}), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Normal run after reset
        rd_ready = 1'b1;
        rq.push_back({1'b0, 8'h40, 8'h70});
        rq.push_back({1'b1, 8'h41, 8'h71});
        start_run(8'h40, 9'd2);
        load_beat(8'h80, 8'h77, 1'b1);
        wait_done("done_t6c");
        chk("t6c_rq_empty", 32'(rq.size()), 32'd0);
        chk("t6c_wq_empty", 32'(wq.size()), 32'd0);
        chk("t6c_timed_out", 32'(timed_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
